user_module_seg_scroller: RTL

USER_MODULE_SEG_SCROLLER -- requirements
Module: user_module_seg_scroller

---
 rtl/user_module_seg_scroller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/user_module_seg_scroller.sv
`default_nettype none
// ============================================================================
// user_module_seg_scroller : scrolls a message across a single 7-seg digit
// Rev 1.0
// ============================================================================
module user_module_seg_scroller #(
  parameter int MSG_LEN = 12,
  parameter logic [MSG_LEN*8-1:0] MSG = {8'h00, 8'h00, 8'h39, 8'h06,
                                         8'h6D, 8'h77, 8'h00, 8'h3F,
                                         8'h38, 8'h38, 8'h79, 8'h76},
  parameter int DWELL_W = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(MSG_LEN - 1);
  localparam logic [DWELL_W-1:0] C_FULL = '1;
  localparam logic [DWELL_W-1:0] C_HALF = C_FULL >> 1;
  localparam logic [7:0] C_BLANK = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic clk, rst, pause, dir, oneshot, fast, blink;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign pause     = io_in[2];
  assign dir       = io_in[3];
  assign oneshot   = io_in[4];
  assign fast      = io_in[5];
  assign blink     = io_in[6];
  assign unused_in = io_in[7];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] presc_q, presc_d;
  logic [7:0]         io_out_q, io_out_d;

  logic [DWELL_W-1:0] tick_mask;
  logic               tick;
  logic               half_msb;
  logic [IDX_W-1:0]   next_idx;
  logic [IDX_W-1:0]   last_char;
  logic [7:0]         char_code;
  logic [7:0]         seg;

  // fast mode shortens the effective prescaler by one bit
  assign tick_mask = fast ? C_HALF : C_FULL;
  assign tick      = (presc_q & tick_mask) == tick_mask;
  assign half_msb  = fast ? presc_q[DWELL_W-2] : presc_q[DWELL_W-1];
  assign last_char = dir ? '0 : C_LAST;

  always_comb begin
    next_idx = '0;
    if (dir) begin
      next_idx = (idx_q == '0) ? C_LAST : idx_q - IDX_W'(1);
    end else begin
      next_idx = (idx_q == C_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    char_code = 8'h00;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx_q == IDX_W'(i)) char_code = MSG[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    unique case (state_q)
      RUN: begin
        if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          presc_d = '0;
          if (oneshot && (idx_q == last_char)) state_d = DONE;
          else                                 idx_d   = next_idx;
        end else begin
          presc_d = presc_q + DWELL_W'(1);
        end
      end
      PAUSE: begin
        if (!pause) state_d = RUN;
      end
      DONE: begin
        presc_d = '0;
        if (!oneshot) begin
          state_d = RUN;
          idx_d   = dir ? C_LAST : '0;
        end
      end
      default: begin
        state_d = RUN;
        idx_d   = '0;
        presc_d = '0;
      end
    endcase
  end

  // output is built from the current registers, giving one cycle of latency
  always_comb begin
    seg = 8'h00;
    unique case (state_q)
      RUN:     if (!(blink && half_msb)) seg = {1'b0, char_code[6:0]};
      PAUSE:   seg = {1'b1, char_code[6:0]};
      default: seg = 8'h00;
    endcase
    io_out_d = (ACTIVE_LOW != 0) ? ~seg : seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      idx_q    <= '0;
      presc_q  <= '0;
      io_out_q <= C_BLANK;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      io_out_q <= io_out_d;
    end
  end

  assign io_out = io_out_q;

endmodule
`default_nettype wire
